// File: rtl/product_decoder.sv
// Serial unary product-stream decoder: counts 1 samples over a WINDOW-long window.
// Optional macro PRODUCT_DECODER_EDGE_EN counts only 0->1 transitions instead of levels.
module product_decoder #(
   parameter int WINDOW = 225,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_rdy,
   input  logic             in,
   output logic [CNT_W-1:0] count,
   output logic             out_rdy,
   output logic             busy
);

   localparam int BW = $clog2(WINDOW + 1);
   localparam logic [BW-1:0] LAST = BW'(WINDOW - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] acc, acc_sum;
   logic [BW-1:0]    bit_cnt;
   logic             hit;
   logic             start;

   assign start = (state != ACCUM) && in_rdy;

`ifdef PRODUCT_DECODER_EDGE_EN
   logic prev;

   assign hit = in & ~prev;

   // prev is cleared at window start so a leading 1 counts as an edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset)               prev <= 1'b0;
      else if (start)          prev <= 1'b0;
      else if (state == ACCUM) prev <= in;
   end
`else
   assign hit = in;
`endif

   // saturating increment: never wraps past all-ones
   always_comb begin
      acc_sum = acc;
      if (hit && (acc != '1)) acc_sum = acc + CNT_W'(1);
   end

   always_comb begin
      state_nxt = state;
      out_rdy   = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE, DONE: state_nxt = in_rdy ? ACCUM : IDLE;
         ACCUM:      if (bit_cnt == LAST) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
      out_rdy = (state == DONE);
      busy    = (state == ACCUM);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         acc     <= '0;
         bit_cnt <= '0;
         count   <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            acc     <= '0;
            bit_cnt <= '0;
         end else if (state == ACCUM) begin
            acc     <= acc_sum;
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST) count <= acc_sum;
         end
      end
   end

endmodule

// File: doc/product_decoder.md
PRODUCT_DECODER -- requirements
Module: product_decoder

Interface
REQ-001 Parameter WINDOW, default 225, meaning: number of serial bit-times in one decode window (legal range 1..255).
REQ-002 Parameter CNT_W, default 8, meaning: width of the decoded count.
REQ-003 clk  input  1  meaning: single clock; all state changes on its rising edge.
REQ-004 reset  input  1  meaning: asynchronous, active-high reset.
REQ-005 in_rdy  input  1  meaning: start-of-window strobe from the product-stream source.
REQ-006 in  input  1  meaning: serial unary product stream, one bit per cycle.
REQ-007 count  output  CNT_W  meaning: decoded value of the last completed window.
REQ-008 out_rdy  output  1  meaning: one-cycle pulse marking a new valid count.
REQ-009 busy  output  1  meaning: high while a window is being accumulated.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-011 In IDLE or DONE, in_rdy=1 at a rising edge SHALL move the FSM to ACCUM, clear the accumulator and clear the bit-time counter.
REQ-012 In IDLE or DONE with in_rdy=0, the FSM SHALL go to or remain in IDLE.
REQ-013 In ACCUM, each rising edge SHALL sample in, add the sample to the accumulator and increment the bit-time counter.
REQ-014 If in_rdy is sampled at edge k, in SHALL be sampled at edges k+1 through k+WINDOW inclusive, which is exactly WINDOW samples.
REQ-015 At edge k+WINDOW, the FSM SHALL enter DONE and load count with the final accumulator value, including the sample taken on that edge.
REQ-016 out_rdy SHALL be 1 only in DONE, giving a pulse exactly one cycle wide.
REQ-017 count SHALL hold its value from the DONE load until the next DONE load.
REQ-018 count SHALL be unchanged while a window is in progress.
REQ-019 busy SHALL be 1 exactly when the FSM is in ACCUM.
REQ-020 in_rdy asserted during ACCUM SHALL be ignored, with no restart and no effect on the count.
REQ-021 in_rdy=1 in the DONE cycle SHALL start a new window back-to-back, with no idle cycle in between.
REQ-022 The accumulator SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-023 The bit-time counter SHALL be wide enough to hold WINDOW without wrapping.
REQ-024 in SHALL be ignored outside ACCUM.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, count=0, out_rdy=0, busy=0, accumulator=0 and bit-time counter=0, independent of clk.
REQ-026 A reset asserted mid-window SHALL abort the window, produce no out_rdy and leave count=0.
REQ-027 After reset is released, the first in_rdy SHALL start a normal window.

Configuration
REQ-028 When macro PRODUCT_DECODER_EDGE_EN is defined, the accumulator SHALL increment only on ACCUM samples where in=1 and the previous ACCUM sample was 0.
REQ-029 In edge mode, the previous-sample register SHALL be cleared at window start, so a 1 on the first sample counts.
REQ-030 When PRODUCT_DECODER_EDGE_EN is not defined, the accumulator SHALL increment on every ACCUM sample where in=1 (level mode).

Verification
REQ-031 Scenario: level mode, WINDOW=225, in_rdy pulse, then in=1 for exactly 6 of the 225 cycles -> count=6 and out_rdy high for 1 cycle, 225 cycles after the in_rdy edge.
REQ-032 Scenario: level mode, WINDOW=8, in=1 for all 8 samples -> count=8; then a second window with in=0 throughout -> count=0, and count holds 8 until that second DONE.
REQ-033 Scenario: in_rdy held high continuously with WINDOW=4 -> out_rdy pulses every 5 cycles and busy drops for exactly 1 cycle between windows.
REQ-034 Scenario: reset asserted after 3 samples of a WINDOW=8 window with in=1 -> immediately count=0 and busy=0, and no out_rdy follows.
REQ-035 Scenario: CNT_W=3, WINDOW=10, in=1 throughout -> count saturates at 7.
REQ-036 Scenario: PRODUCT_DECODER_EDGE_EN defined, WINDOW=8, in pattern 1,1,0,1,0,0,1,1 -> count=3; the same pattern without the macro -> count=5.
